// File: rtl/exception_flush_ctrl_if.sv
// Handshake bundle between the MEM-stage exception logic, data bus monitor, CP0 and fetch.
// The master side raises requests; the slave side is the flush sequencer.
interface exception_flush_ctrl_if;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        mem_req_fire;
    logic        mem_resp_fire;
    logic        redirect_ready;
    logic        flush;
    logic        cp0_commit;
    logic        cp0_commit_eret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        err;

    modport master (
        output exc_req, eret_req, epc, mem_req_fire, mem_resp_fire, redirect_ready,
        input  flush, cp0_commit, cp0_commit_eret, redirect_valid, redirect_pc, busy, err
    );

    modport slave (
        input  exc_req, eret_req, epc, mem_req_fire, mem_resp_fire, redirect_ready,
        output flush, cp0_commit, cp0_commit_eret, redirect_valid, redirect_pc, busy, err
    );
endinterface

// File: rtl/exception_flush_ctrl.sv
// Exception-entry / ERET sequencer: flush, drain data bus, commit to CP0, redirect fetch.
// Optional drain timeout enabled by defining EXC_FLUSH_TIMEOUT_EN.
module exception_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                  clk,
    input logic                  resetn,
    exception_flush_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    if (TIMEOUT == 0) begin : g_timeout_check
        $error("TIMEOUT must be nonzero");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_err;
    logic             err_q;
    logic             kind_q;
    logic [31:0]      target_q;
    logic             flush_q;
    logic             busy_q;
    logic             commit_q;
    logic             rvalid_q;

`ifdef EXC_FLUSH_TIMEOUT_EN
    localparam int unsigned    TmrW    = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
    logic [TmrW-1:0] tmr_q;
`endif

    // Saturating outstanding-transaction counter; over/underflow attempts flag err.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_err = 1'b0;
        if (bus.mem_req_fire && !bus.mem_resp_fire) begin
            if (cnt_q == CntMax) cnt_err = 1'b1;
            else                 cnt_d   = cnt_q + CNT_W'(1);
        end else if (bus.mem_resp_fire && !bus.mem_req_fire) begin
            if (cnt_q == '0) cnt_err = 1'b1;
            else             cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            kind_q   <= 1'b0;
            target_q <= '0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            rvalid_q <= 1'b0;
`ifdef EXC_FLUSH_TIMEOUT_EN
            tmr_q    <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            err_q    <= err_q | cnt_err;
            commit_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef EXC_FLUSH_TIMEOUT_EN
                    tmr_q <= '0;
`endif
                    if (bus.exc_req || bus.eret_req) begin
                        kind_q   <= !bus.exc_req;
                        target_q <= bus.exc_req ? EXC_VECTOR : bus.epc;
                        state_q  <= StDrain;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StDrain: begin
`ifdef EXC_FLUSH_TIMEOUT_EN
                    tmr_q <= tmr_q + TmrW'(1);
                    if (cnt_d == '0) begin
                        state_q  <= StCommit;
                        commit_q <= 1'b1;
                    end else if (tmr_q == TmrLast) begin
                        // Give up on the lost responses and proceed.
                        cnt_q    <= '0;
                        err_q    <= 1'b1;
                        state_q  <= StCommit;
                        commit_q <= 1'b1;
                    end
`else
                    if (cnt_d == '0) begin
                        state_q  <= StCommit;
                        commit_q <= 1'b1;
                    end
`endif
                end
                StCommit: begin
                    state_q  <= StRedirect;
                    rvalid_q <= 1'b1;
                end
                StRedirect: begin
                    if (bus.redirect_ready) begin
                        state_q  <= StIdle;
                        rvalid_q <= 1'b0;
                        flush_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.flush           = flush_q;
    assign bus.busy            = busy_q;
    assign bus.cp0_commit      = commit_q;
    assign bus.cp0_commit_eret = kind_q;
    assign bus.redirect_valid  = rvalid_q;
    assign bus.redirect_pc     = target_q;
    assign bus.err             = err_q;

endmodule
